// File: rtl/array_14_port_ctrl.sv
// array_14_port_ctrl: round-robin write/read arbiter onto a single-port lane-masked SRAM with an in-order 2-entry read response FIFO.
module array_14_port_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LANES  = 16,
  parameter int LANE_W = 33,
  parameter int DATA_W = LANES * LANE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LANES-1:0]  wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [LANES-1:0]  sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  logic              r_last_grant;
  logic              r_inflight;
  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_fifo [2];
  logic              w_pop;
  logic              w_space;
  logic              w_rd_elig;
  assign resp_valid = r_count != 2'd0;
  assign resp_data  = r_fifo[r_head];
  assign w_pop      = resp_valid && resp_ready;
  // A read may only issue if the FIFO can absorb it plus the one already in flight.
  assign w_space    = ({1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2;
  assign w_rd_elig  = rd_valid && w_space;
  assign wr_ready   = !reset && wr_valid && (!w_rd_elig || r_last_grant);
  assign rd_ready   = !reset && w_rd_elig && (!wr_valid || !r_last_grant);
  assign sram_en    = wr_ready || rd_ready;
  assign sram_wmode = wr_ready;
  assign sram_addr  = wr_ready ? wr_addr : rd_ready ? rd_addr : '0;
  assign sram_wmask = wr_ready ? wr_mask : '0;
  assign sram_wdata = wr_ready ? wr_data : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_inflight   <= 1'b0;
      r_head       <= 1'b0;
      r_tail       <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      if (sram_en) r_last_grant <= rd_ready;
      r_inflight <= rd_ready;
      if (r_inflight) r_tail <= ~r_tail;
      if (w_pop) r_head <= ~r_head;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end
  // Macro output is only stable the cycle after issue, so capture it then.
  always_ff @(posedge clock) begin
    if (!reset && r_inflight) r_fifo[r_tail] <= sram_rdata;
  end
endmodule
